// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//   Read-address arbiter for a 2-way AXI channel mux. It grants one of two
//   masters and holds the mux select from the AR handshake through the
//   RLAST beat. It also counts R beats against the granted ARLEN and raises a
//   sticky error on a mismatch.
//
//   Build option:
//     AXI_ARB_FIXED_PRIO_EN  when defined, M0 always wins simultaneous
//                            requests. When undefined (default), simultaneous
//                            requests are served round-robin.
//
//   Ports:
//     ACLK, ARESETn           clock; asynchronous active-low reset
//     ARVALID_M0/M1           read-address valid from each master
//     ARLEN_M0/M1             burst length from each master (beats = ARLEN+1)
//     ARREADY                 read-address ready for the granted master
//     RVALID, RREADY, RLAST   R-channel handshake of the granted master
//     pointer                 mux select: 0 none, 1 M0, 2 M1 (registered)
//     busy                    high while a transaction is in flight
//     len_err                 sticky: RLAST arrived on the wrong beat
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int unsigned PTR_W = 2,
  parameter int unsigned LEN_W = 4
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             ARVALID_M0,
  input  logic             ARVALID_M1,
  input  logic [LEN_W-1:0] ARLEN_M0,
  input  logic [LEN_W-1:0] ARLEN_M1,
  input  logic             ARREADY,
  input  logic             RVALID,
  input  logic             RREADY,
  input  logic             RLAST,
  output logic [PTR_W-1:0] pointer,
  output logic             busy,
  output logic             len_err
);

  localparam int unsigned CNT_W = LEN_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PTR_W-1:0] PTR_NONE = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_M0   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_M1   = PTR_W'(2);

`ifdef AXI_ARB_FIXED_PRIO_EN
  localparam logic RR_EN = 1'b0;
`else
  localparam logic RR_EN = 1'b1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [PTR_W-1:0] pointer_d;
  logic             busy_d;
  logic             len_err_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_d;
  // Last master served: 0 = M0, 1 = M1.
  logic             last_grant;
  logic             last_grant_d;

  logic             ar_req;
  logic             pick_m1;
  logic             gnt_m1;
  logic             ar_hs;
  logic             r_hs;
  logic             at_len;

  // Request decode and handshake qualifiers.
  always_comb begin
    ar_req  = ARVALID_M0 | ARVALID_M1;
    // M1 wins when alone, or on contention when round-robin favours it.
    pick_m1 = ARVALID_M1 & (~ARVALID_M0 | (RR_EN & ~last_grant));
    gnt_m1  = (pointer == PTR_M1);
    ar_hs   = (gnt_m1 ? ARVALID_M1 : ARVALID_M0) & ARREADY;
    r_hs    = RVALID & RREADY;
    // Beats already received equals ARLEN: the current beat must be the last.
    at_len  = (beat_cnt == CNT_W'(len_q));
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (ar_req) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        // A granted master dropping ARVALID just stalls here.
        if (ar_hs) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (r_hs && RLAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    pointer_d    = pointer;
    len_d        = len_q;
    beat_d       = beat_cnt;
    len_err_d    = len_err;
    last_grant_d = last_grant;
    case (state)
      IDLE: begin
        if (ar_req) begin
          pointer_d = pick_m1 ? PTR_M1 : PTR_M0;
          len_d     = pick_m1 ? ARLEN_M1 : ARLEN_M0;
          beat_d    = '0;
        end
      end
      DATA: begin
        if (r_hs) begin
          if (beat_cnt != CNT_MAX) begin
            beat_d = beat_cnt + CNT_W'(1);
          end
          if (RLAST) begin
            if (!at_len) begin
              len_err_d = 1'b1;
            end
            last_grant_d = gnt_m1;
            pointer_d    = PTR_NONE;
          end else if (at_len) begin
            // Overrun: one beat more than ARLEN allows and still no RLAST.
            len_err_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output and datapath registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      pointer    <= PTR_NONE;
      busy       <= 1'b0;
      len_err    <= 1'b0;
      len_q      <= '0;
      beat_cnt   <= '0;
      last_grant <= 1'b1;
    end else begin
      pointer    <= pointer_d;
      busy       <= busy_d;
      len_err    <= len_err_d;
      len_q      <= len_d;
      beat_cnt   <= beat_d;
      last_grant <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//   Directed scenarios with literal expectations, then randomized master and
//   slave traffic. A transaction-level model predicts pointer/busy/len_err
//   and a compare process checks them on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ARVALID_M0, ARVALID_M1;
  logic [3:0] ARLEN_M0, ARLEN_M1;
  logic       ARREADY, RVALID, RREADY, RLAST;
  logic [1:0] pointer;
  logic       busy, len_err;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  axi_rd_arbiter #(.PTR_W(2), .LEN_W(4)) dut (
    .ACLK       (clk),
    .ARESETn    (rst_n),
    .ARVALID_M0 (ARVALID_M0),
    .ARVALID_M1 (ARVALID_M1),
    .ARLEN_M0   (ARLEN_M0),
    .ARLEN_M1   (ARLEN_M1),
    .ARREADY    (ARREADY),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .RLAST      (RLAST),
    .pointer    (pointer),
    .busy       (busy),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 no transaction, 1 M0, 2 M1. addr_done: AR handshake seen.
  int m_owner = 0;
  bit m_addr_done = 1'b0;
  int m_beats = 0;
  int m_len = 0;
  bit m_err = 1'b0;
  int m_last = 2;

  function automatic int pick(input bit a0, input bit a1, input int last);
    if (a0 && !a1) return 1;
    if (a1 && !a0) return 2;
`ifdef AXI_ARB_FIXED_PRIO_EN
    return 1;
`else
    return (last == 1) ? 2 : 1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner     <= 0;
      m_addr_done <= 1'b0;
      m_beats     <= 0;
      m_len       <= 0;
      m_err       <= 1'b0;
      m_last      <= 2;
    end else if (m_owner == 0) begin
      if (ARVALID_M0 || ARVALID_M1) begin
        m_owner     <= pick(ARVALID_M0, ARVALID_M1, m_last);
        m_len       <= (pick(ARVALID_M0, ARVALID_M1, m_last) == 1) ? int'(ARLEN_M0) : int'(ARLEN_M1);
        m_beats     <= 0;
        m_addr_done <= 1'b0;
      end
    end else if (!m_addr_done) begin
      if (ARREADY && ((m_owner == 1) ? ARVALID_M0 : ARVALID_M1)) m_addr_done <= 1'b1;
    end else if (RVALID && RREADY) begin
      if (m_beats < 31) m_beats <= m_beats + 1;
      if (RLAST) begin
        if (m_beats != m_len) m_err <= 1'b1;
        m_last  <= m_owner;
        m_owner <= 0;
      end else if (m_beats == m_len) begin
        m_err <= 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_pointer", int'(pointer), m_owner);
      chk("cyc_busy", int'(busy), int'(m_owner != 0));
      chk("cyc_len_err", int'(len_err), int'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
    ARLEN_M0 = 4'd0; ARLEN_M1 = 4'd0;
    ARREADY = 1'b0; RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  // One directed transaction: request, ARREADY immediately, then beats with
  // RLAST on beat index last_idx. Returns the pointer seen after the grant.
  task automatic do_txn(input int m, input int len, input int last_idx,
                        input bit both, output int gptr);
    ARVALID_M0 = both || (m == 0);
    ARVALID_M1 = both || (m == 1);
    ARLEN_M0 = 4'(len);
    ARLEN_M1 = 4'(len);
    ARREADY = 1'b0;
    tick();
    gptr = int'(pointer);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    if (!both) begin
      ARVALID_M0 = 1'b0;
      ARVALID_M1 = 1'b0;
    end
    RVALID = 1'b1;
    RREADY = 1'b1;
    for (int b = 0; b <= last_idx; b++) begin
      RLAST = (b == last_idx);
      tick();
    end
    RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
  endtask

  // ---------------- random environment ----------------
  bit e_pend [2];
  int e_len  [2];
  int e_phase;  // 0 idle, 1 address, 2 data
  int e_gm;
  int e_tgt;
  int e_beats;

  task automatic env_reset();
    e_pend[0] = 1'b0; e_pend[1] = 1'b0;
    e_len[0] = 0; e_len[1] = 0;
    e_phase = 0; e_gm = 0; e_tgt = 0; e_beats = 0;
  endtask

  task automatic env_step();
    bit hs_ar, hs_r;
    bit a0, a1;
    int r;
    // What happened at the edge just passed (inputs still hold their values).
    hs_ar = (e_phase == 1) && ARREADY && ((e_gm == 0) ? ARVALID_M0 : ARVALID_M1);
    hs_r  = (e_phase == 2) && RVALID && RREADY;
    if (hs_ar) begin
      e_phase = 2;
      e_beats = 0;
      e_pend[e_gm] = 1'b0;
    end else if (hs_r) begin
      if (RLAST) e_phase = 0;
      else e_beats++;
    end
    if (e_phase == 0 && pointer != 2'd0) begin
      e_phase = 1;
      e_gm = int'(pointer) - 1;
      r = int'($urandom_range(0, 15));
      if (r == 0 && e_len[e_gm] > 0) e_tgt = int'($urandom_range(0, e_len[e_gm] - 1));
      else if (r == 1) e_tgt = e_len[e_gm] + int'($urandom_range(1, 3));
      else e_tgt = e_len[e_gm];
    end
    for (int m = 0; m < 2; m++) begin
      if (!e_pend[m] && $urandom_range(0, 3) == 0) begin
        e_pend[m] = 1'b1;
        e_len[m] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      end
    end
    a0 = e_pend[0] && ($urandom_range(0, 7) != 0);
    a1 = e_pend[1] && ($urandom_range(0, 7) != 0);
    ARVALID_M0 = a0;
    ARVALID_M1 = a1;
    ARLEN_M0 = e_pend[0] ? 4'(e_len[0]) : 4'($urandom_range(0, 15));
    ARLEN_M1 = e_pend[1] ? 4'(e_len[1]) : 4'($urandom_range(0, 15));
    ARREADY = 1'($urandom_range(0, 1));
    if (e_phase == 2) begin
      RVALID = ($urandom_range(0, 3) != 0);
      RREADY = ($urandom_range(0, 3) != 0);
      RLAST  = (e_beats == e_tgt);
    end else begin
      RVALID = 1'($urandom_range(0, 1));
      RREADY = 1'($urandom_range(0, 1));
      RLAST  = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int g;
    rst_n = 1'b0;
    clear_inputs();
    env_reset();
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    chk("rst_pointer", int'(pointer), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_len_err", int'(len_err), 0);

    // Single M0 burst of 4 beats, ARREADY two cycles after the request.
    ARVALID_M0 = 1'b1; ARLEN_M0 = 4'd3;
    tick();
    chk("t1_grant_ptr", int'(pointer), 1);
    chk("t1_grant_busy", int'(busy), 1);
    chk("t1_model_ptr", m_owner, 1);
    tick();
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0; ARVALID_M0 = 1'b0;
    RVALID = 1'b1; RREADY = 1'b1;
    for (int b = 0; b < 4; b++) begin
      RLAST = (b == 3);
      tick();
      if (b < 3) chk("t1_hold_ptr", int'(pointer), 1);
    end
    RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
    chk("t1_end_ptr", int'(pointer), 0);
    chk("t1_end_busy", int'(busy), 0);
    chk("t1_len_err", int'(len_err), 0);

    // Both masters requesting for three single-beat transactions.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_txn(0, 0, 0, 1'b1, g);
`ifdef AXI_ARB_FIXED_PRIO_EN
      chk("t2_grant_order", g, 1);
`else
      chk("t2_grant_order", g, (i == 1) ? 2 : 1);
`endif
      chk("t2_gap_ptr", int'(pointer), 0);
    end
    clear_inputs();

    // Early RLAST on M1 sets a sticky error.
    do_reset();
    do_txn(1, 2, 1, 1'b0, g);
    chk("t3_grant_ptr", g, 2);
    chk("t3_len_err", int'(len_err), 1);
    chk("t3_idle_ptr", int'(pointer), 0);
    chk("t3_idle_busy", int'(busy), 0);
    do_txn(0, 1, 1, 1'b0, g);
    chk("t3_sticky", int'(len_err), 1);
    do_reset();
    chk("t3_cleared", int'(len_err), 0);

    // M1 request during M0 data phase waits for M0's RLAST plus one idle cycle.
    ARVALID_M0 = 1'b1; ARLEN_M0 = 4'd3;
    tick();
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0; ARVALID_M0 = 1'b0;
    RVALID = 1'b1; RREADY = 1'b1;
    ARVALID_M1 = 1'b1; ARLEN_M1 = 4'd0;
    for (int b = 0; b < 4; b++) begin
      RLAST = (b == 3);
      tick();
      if (b < 3) chk("t4_hold_ptr", int'(pointer), 1);
    end
    RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
    chk("t4_gap_ptr", int'(pointer), 0);
    tick();
    chk("t4_m1_ptr", int'(pointer), 2);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0; ARVALID_M1 = 1'b0;
    RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
    tick();
    RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
    chk("t4_end_ptr", int'(pointer), 0);
    chk("t4_len_err", int'(len_err), 0);

    // Reset during beat 2 of an M0 burst, then M1 alone.
    ARVALID_M0 = 1'b1; ARLEN_M0 = 4'd3;
    tick();
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0; ARVALID_M0 = 1'b0;
    RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_async_ptr", int'(pointer), 0);
    chk("t5_async_busy", int'(busy), 0);
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    ARVALID_M1 = 1'b1; ARLEN_M1 = 4'd0;
    tick();
    chk("t5_m1_ptr", int'(pointer), 2);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0; ARVALID_M1 = 1'b0;
    RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
    tick();
    clear_inputs();
    tick();

    // R-channel activity while idle is ignored.
    RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
    tick();
    chk("t6_ptr", int'(pointer), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_len_err", int'(len_err), 0);
    tick();
    clear_inputs();

    // Randomized traffic in segments, each ending with a reset.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      env_reset();
      for (int c = 0; c < 800; c++) begin
        env_step();
        tick();
      end
      rst_n = 1'b0;
      clear_inputs();
      #1;
      chk("rnd_rst_ptr", int'(pointer), 0);
      chk("rnd_rst_busy", int'(busy), 0);
      chk("rnd_rst_len_err", int'(len_err), 0);
      tick();
      rst_n = 1'b1;
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
